// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV32I pipeline.
//
// Drives a req/gnt/rvalid data-memory port, generates store byte-enables and
// lane-replicated write data, extracts and extends load data, and owns the
// MEM/WB pipeline register presented to writeback.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   ValidM .. funct3M   held EX/MEM register contents
//   dmem_*              data-memory request/response port
//   StallM              hold EX/MEM and all earlier stages
//   MisalignM           misaligned or illegal access this cycle
//   memwb_o             MEM/WB register
//   dbg_state           current FSM state (0 = IDLE, 1 = WAIT_R)
//
// Memory handshake:
//   dmem_req is held high with stable addr/be/wdata/we until a cycle in which
//   dmem_gnt is also high; that cycle completes the request. A store is then
//   finished. A load waits for dmem_rvalid, which comes no earlier than the
//   cycle after gnt, with dmem_rdata valid in the same cycle. Only one
//   transaction is ever outstanding, and dmem_req is low while waiting.

package pipeline_pkg;
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] load_data;
    logic [31:0] pc_plus4;
    logic [31:0] imm_ext;
    logic [1:0]  result_src;
    logic [4:0]  rd;
    logic        reg_write;
  } memwb_t;
endpackage

module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ValidM,
  input  logic [XLEN-1:0]      ALUResultM,
  input  logic [XLEN-1:0]      WriteDataM,
  input  logic [XLEN-1:0]      PCPlus4M,
  input  logic [XLEN-1:0]      ImmExtM,
  input  logic [4:0]           RdM,
  input  logic                 RegWriteM,
  input  logic [1:0]           ResultSrcM,
  input  logic                 MemReadM,
  input  logic                 MemWriteM,
  input  logic [2:0]           funct3M,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [3:0]           dmem_be,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic                 dmem_gnt,
  input  logic                 dmem_rvalid,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic                 StallM,
  output logic                 MisalignM,
  output pipeline_pkg::memwb_t memwb_o,
  output logic                 dbg_state
);

  typedef enum logic {
    IDLE   = 1'b0,
    WAIT_R = 1'b1
  } state_t;

  state_t state;

  logic [1:0]  lane;
  logic        access;
  logic        bad_access;
  logic        legal_access;
  logic        load_done;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign lane         = ALUResultM[1:0];
  assign access       = ValidM & (MemReadM | MemWriteM);
  assign MisalignM    = access & bad_access;
  assign legal_access = access & ~bad_access;
  assign dmem_addr    = {ALUResultM[XLEN-1:2], 2'b00};
  assign dbg_state    = state;

  // Alignment and funct3 legality. funct3[1:0] is the access size; bit 2
  // (unsigned) only makes sense for byte/half loads.
  always_comb begin
    bad_access = 1'b0;
    case (funct3M[1:0])
      2'b00:   bad_access = 1'b0;
      2'b01:   bad_access = lane[0];
      2'b10:   bad_access = |lane;
      default: bad_access = 1'b1;
    endcase
    if (funct3M[2] & (MemWriteM | funct3M[1])) bad_access = 1'b1;
    if (MemReadM & MemWriteM)                  bad_access = 1'b1;
  end

  // Request and stall decode. Reset forces the port quiet even though the
  // state register is already IDLE, so a held access cannot leak a request.
  always_comb begin
    dmem_req = 1'b0;
    StallM   = 1'b0;
    case (state)
      IDLE: begin
        dmem_req = legal_access;
        // A store granted this cycle is complete; anything else still waits.
        StallM   = legal_access & ~(MemWriteM & dmem_gnt);
      end
      WAIT_R: begin
        dmem_req = 1'b0;
        StallM   = ~dmem_rvalid;
      end
      default: begin
        dmem_req = 1'b0;
        StallM   = 1'b0;
      end
    endcase
    if (reset) begin
      dmem_req = 1'b0;
      StallM   = 1'b0;
    end
  end

  assign dmem_we   = dmem_req & MemWriteM;
  assign load_done = (state == WAIT_R) & dmem_rvalid;

  // Byte enables and lane-replicated store data.
  always_comb begin
    dmem_be    = 4'b0000;
    dmem_wdata = WriteDataM;
    if (MemWriteM) begin
      case (funct3M[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << lane;
          dmem_wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          dmem_be    = 4'b0011 << lane;
          dmem_wdata = {2{WriteDataM[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = WriteDataM;
        end
      endcase
    end else begin
      dmem_be = 4'b1111;
    end
    if (!dmem_req) dmem_be = 4'b0000;
  end

  // Load extraction: byte by full lane, half by lane[1].
  always_comb begin
    case (lane)
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3M)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  // FSM and MEM/WB register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      memwb_o <= '0;
    end else begin
      case (state)
        IDLE:    if (legal_access & MemReadM & dmem_gnt) state <= WAIT_R;
        WAIT_R:  if (dmem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (StallM | ~ValidM) begin
        memwb_o <= '0;
      end else begin
        memwb_o.alu_result <= ALUResultM;
        memwb_o.load_data  <= load_done ? load_data : 32'd0;
        memwb_o.pc_plus4   <= PCPlus4M;
        memwb_o.imm_ext    <= ImmExtM;
        memwb_o.result_src <= ResultSrcM;
        memwb_o.rd         <= RdM;
        memwb_o.reg_write  <= RegWriteM & ~MisalignM;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized instructions
// checked against a behavioural model of the stage.
module tb_mem_stage;
  import pipeline_pkg::*;

  localparam int MW = $bits(memwb_t);

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  rs;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
  } instr_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        ValidM, RegWriteM, MemReadM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, ImmExtM;
  logic [4:0]  RdM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        StallM, MisalignM, dbg_state;
  memwb_t      memwb_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .ValidM(ValidM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
    .RdM(RdM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .StallM(StallM),
    .MisalignM(MisalignM), .memwb_o(memwb_o), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic bit model_bad(instr_t i);
    int unsigned a = i.alu % 4;
    if (i.mr && i.mw) return 1'b1;
    if (i.mw) begin
      case (i.f3)
        3'd0:    return 1'b0;
        3'd1:    return (a % 2) != 0;
        3'd2:    return a != 0;
        default: return 1'b1;
      endcase
    end
    case (i.f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (a % 2) != 0;
      3'd2:       return a != 0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] addr,
                                             logic [31:0] rdata);
    int unsigned ln = addr % 4;
    logic [31:0] b  = (rdata >> (8 * ln)) & 32'hFF;
    logic [31:0] h  = (rdata >> (16 * (ln / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFFFF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] model_be(instr_t i);
    int unsigned ln = i.alu % 4;
    if (!i.mw) return 4'hF;
    case (i.f3)
      3'd0:    return 4'(32'd1 << ln);
      3'd1:    return 4'(32'd3 << ln);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(instr_t i);
    case (i.f3)
      3'd0:    return {24'd0, i.wd[7:0]} * 32'h01010101;
      3'd1:    return {16'd0, i.wd[15:0]} * 32'h00010001;
      default: return i.wd;
    endcase
  endfunction

  function automatic memwb_t model_memwb(instr_t i, logic [31:0] rdata);
    memwb_t m = '0;
    bit acc = i.valid && (i.mr || i.mw);
    bit bad = acc && model_bad(i);
    if (!i.valid) return m;
    m.alu_result = i.alu;
    m.pc_plus4   = i.pc4;
    m.imm_ext    = i.imm;
    m.result_src = i.rs;
    m.rd         = i.rd;
    m.reg_write  = i.rw && !bad;
    if (acc && !bad && i.mr) m.load_data = model_load(i.f3, i.alu, rdata);
    return m;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input instr_t i);
    ValidM = i.valid; ALUResultM = i.alu; WriteDataM = i.wd; PCPlus4M = i.pc4;
    ImmExtM = i.imm; RdM = i.rd; RegWriteM = i.rw; ResultSrcM = i.rs;
    MemReadM = i.mr; MemWriteM = i.mw; funct3M = i.f3;
  endtask

  task automatic idle_inputs();
    instr_t z = '0;
    apply(z);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic instr_t mk(logic [31:0] alu, logic [31:0] wd, logic [4:0] rd,
                                logic rw, logic mr, logic mw, logic [2:0] f3);
    instr_t i;
    i.valid = 1'b1; i.alu = alu; i.wd = wd; i.pc4 = 32'h0000_0104;
    i.imm = 32'h0000_0010; i.rd = rd; i.rw = rw; i.rs = mr ? 2'd1 : 2'd0;
    i.mr = mr; i.mw = mw; i.f3 = f3;
    return i;
  endfunction

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    n_checks++; if (memwb_o !== '0) $display("FAIL reset_memwb: got %h want 0", memwb_o); else n_pass++;
    n_checks++; if (StallM !== 1'b0) $display("FAIL reset_stall: got %b want 0", StallM); else n_pass++;
    n_checks++; if (dmem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", dmem_req); else n_pass++;
    n_checks++; if (dbg_state !== 1'b0) $display("FAIL reset_state: got %b want 0", dbg_state); else n_pass++;
    @(negedge clk); reset = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    instr_t i = mk(32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd2);
    memwb_t exp = model_memwb(i, 32'd0);
    apply(i);
    @(negedge clk);
    n_checks++; if (StallM !== 1'b0) $display("FAIL alu_stall: got %b want 0", StallM); else n_pass++;
    n_checks++; if (dmem_req !== 1'b0) $display("FAIL alu_req: got %b want 0", dmem_req); else n_pass++;
    tick();
    n_checks++; if (memwb_o.rd !== 5'd5 || memwb_o.alu_result !== 32'h1234)
      $display("FAIL alu_rd_result: got rd=%0d alu=%h want rd=5 alu=1234", memwb_o.rd, memwb_o.alu_result); else n_pass++;
    n_checks++; if (memwb_o !== exp) $display("FAIL alu_memwb: got %h want %h", memwb_o, exp); else n_pass++;
    idle_inputs();
    tick();
    n_checks++; if (memwb_o !== '0) $display("FAIL alu_bubble: got %h want 0", memwb_o); else n_pass++;
  endtask

  task automatic test_sb();
    instr_t i = mk(32'h0000_1003, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 1'b1, 3'd0);
    memwb_t exp = model_memwb(i, 32'd0);
    apply(i); dmem_gnt = 1'b1;
    @(negedge clk);
    n_checks++; if (dmem_be !== 4'b1000) $display("FAIL sb_be: got %b want 1000", dmem_be); else n_pass++;
    n_checks++; if (dmem_wdata !== 32'hABABABAB) $display("FAIL sb_wdata: got %h want abababab", dmem_wdata); else n_pass++;
    n_checks++; if (dmem_addr !== 32'h0000_1000) $display("FAIL sb_addr: got %h want 00001000", dmem_addr); else n_pass++;
    n_checks++; if (StallM !== 1'b0) $display("FAIL sb_stall: got %b want 0", StallM); else n_pass++;
    n_checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) $display("FAIL sb_req_we: got %b%b want 11", dmem_req, dmem_we); else n_pass++;
    tick();
    n_checks++; if (memwb_o !== exp) $display("FAIL sb_memwb: got %h want %h", memwb_o, exp); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_lb(input bit is_signed);
    instr_t i = mk(32'h0000_2002, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, is_signed ? 3'd0 : 3'd4);
    logic [31:0] want = is_signed ? 32'hFFFF_FF80 : 32'h0000_0080;
    memwb_t exp = model_memwb(i, 32'h0080_FF00);
    apply(i); dmem_gnt = 1'b1;
    @(negedge clk);
    n_checks++; if (StallM !== 1'b1 || dmem_req !== 1'b1) $display("FAIL lb_c0: got stall=%b req=%b want 1 1", StallM, dmem_req); else n_pass++;
    tick(); dmem_gnt = 1'b0;
    n_checks++; if (memwb_o !== '0) $display("FAIL lb_bubble0: got %h want 0", memwb_o); else n_pass++;
    @(negedge clk);
    n_checks++; if (StallM !== 1'b1 || dmem_req !== 1'b0) $display("FAIL lb_c1: got stall=%b req=%b want 1 0", StallM, dmem_req); else n_pass++;
    tick();
    n_checks++; if (memwb_o !== '0) $display("FAIL lb_bubble1: got %h want 0", memwb_o); else n_pass++;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0080_FF00;
    @(negedge clk);
    n_checks++; if (StallM !== 1'b0) $display("FAIL lb_c2_stall: got %b want 0", StallM); else n_pass++;
    tick();
    n_checks++; if (memwb_o.load_data !== want) $display("FAIL lb_data: got %h want %h", memwb_o.load_data, want); else n_pass++;
    n_checks++; if (memwb_o !== exp) $display("FAIL lb_memwb: got %h want %h", memwb_o, exp); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_lw_wait();
    instr_t i = mk(32'h0000_3000, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 3'd2);
    logic [31:0] rd = $urandom;
    memwb_t exp = model_memwb(i, rd);
    apply(i);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h3000 || StallM !== 1'b1)
        $display("FAIL lw_hold%0d: got req=%b addr=%h stall=%b want 1 00003000 1", c, dmem_req, dmem_addr, StallM); else n_pass++;
      tick();
      n_checks++; if (memwb_o !== '0) $display("FAIL lw_bubble%0d: got %h want 0", c, memwb_o); else n_pass++;
    end
    dmem_gnt = 1'b1;
    @(negedge clk);
    n_checks++; if (dmem_req !== 1'b1 || StallM !== 1'b1) $display("FAIL lw_gnt: got req=%b stall=%b want 1 1", dmem_req, StallM); else n_pass++;
    tick(); dmem_gnt = 1'b0;
    @(negedge clk);
    n_checks++; if (dmem_req !== 1'b0 || StallM !== 1'b1) $display("FAIL lw_wait: got req=%b stall=%b want 0 1", dmem_req, StallM); else n_pass++;
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = rd;
    @(negedge clk);
    n_checks++; if (StallM !== 1'b0) $display("FAIL lw_done_stall: got %b want 0", StallM); else n_pass++;
    tick();
    n_checks++; if (memwb_o !== exp) $display("FAIL lw_memwb: got %h want %h", memwb_o, exp); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_misalign();
    instr_t i = mk(32'h0000_4001, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 3'd1);
    memwb_t exp = model_memwb(i, 32'd0);
    apply(i); dmem_gnt = 1'b1;
    @(negedge clk);
    n_checks++; if (MisalignM !== 1'b1) $display("FAIL mis_flag: got %b want 1", MisalignM); else n_pass++;
    n_checks++; if (dmem_req !== 1'b0 || StallM !== 1'b0) $display("FAIL mis_req_stall: got req=%b stall=%b want 0 0", dmem_req, StallM); else n_pass++;
    tick();
    n_checks++; if (memwb_o.reg_write !== 1'b0) $display("FAIL mis_regwrite: got %b want 0", memwb_o.reg_write); else n_pass++;
    n_checks++; if (memwb_o !== exp) $display("FAIL mis_memwb: got %h want %h", memwb_o, exp); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    instr_t i = mk(32'h0000_5004, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 3'd2);
    apply(i); dmem_gnt = 1'b1;
    tick(); dmem_gnt = 1'b0;
    n_checks++; if (dbg_state !== 1'b1) $display("FAIL rmid_wait: got state=%b want 1", dbg_state); else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++; if (dbg_state !== 1'b0 || memwb_o !== '0 || StallM !== 1'b0)
      $display("FAIL rmid_async: got state=%b stall=%b memwb=%h want 0 0 0", dbg_state, StallM, memwb_o); else n_pass++;
    @(negedge clk); reset = 1'b0;
    idle_inputs();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (StallM !== 1'b0) $display("FAIL rmid_stray_stall: got %b want 0", StallM); else n_pass++;
    tick();
    n_checks++; if (dbg_state !== 1'b0 || memwb_o !== '0)
      $display("FAIL rmid_stray: got state=%b memwb=%h want 0 0", dbg_state, memwb_o); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [MW-1:0] exp_q[$];
    for (int n = 0; n < 200; n++) begin
      instr_t      ins;
      logic [31:0] rdata;
      int          kind, gdel, rdel, rv_at, cyc;
      bit          acc, bad, mem, granted, done, g, r, exp_stall;
      logic [MW-1:0] exp;
      kind      = $urandom_range(0, 2);
      ins.valid = ($urandom_range(0, 9) != 0);
      ins.alu   = $urandom;
      if ($urandom_range(0, 1) == 0) ins.alu[1:0] = 2'b00;
      ins.wd = $urandom; ins.pc4 = $urandom; ins.imm = $urandom;
      ins.rd = 5'($urandom_range(0, 31)); ins.rw = 1'($urandom_range(0, 1));
      ins.rs = 2'($urandom_range(0, 3));
      ins.mr = (kind == 1); ins.mw = (kind == 2);
      if ($urandom_range(0, 19) == 0) begin ins.mr = 1'b1; ins.mw = 1'b1; end
      ins.f3 = 3'($urandom_range(0, 7));
      rdata  = $urandom;
      acc = ins.valid && (ins.mr || ins.mw);
      bad = acc && model_bad(ins);
      mem = acc && !bad;
      exp_q.push_back(model_memwb(ins, rdata));
      apply(ins); dmem_rdata = rdata;
      gdel = $urandom_range(0, 3); rdel = $urandom_range(0, 2);
      granted = 1'b0; done = 1'b0; cyc = 0; rv_at = 0;
      while (!done && cyc < 16) begin
        g = mem && !granted && (cyc == gdel);
        r = granted && (cyc == rv_at);
        dmem_gnt = g; dmem_rvalid = r;
        @(negedge clk);
        exp_stall = mem && (granted ? !r : !(ins.mw && g));
        n_checks++; if (StallM !== exp_stall) $display("FAIL rnd%0d_stall c%0d: got %b want %b", n, cyc, StallM, exp_stall); else n_pass++;
        n_checks++; if (dmem_req !== (mem && !granted)) $display("FAIL rnd%0d_req c%0d: got %b want %b", n, cyc, dmem_req, mem && !granted); else n_pass++;
        n_checks++; if (MisalignM !== bad) $display("FAIL rnd%0d_misalign: got %b want %b", n, MisalignM, bad); else n_pass++;
        if (mem && !granted) begin
          n_checks++; if (dmem_be !== model_be(ins) || dmem_we !== ins.mw || dmem_addr !== (ins.alu & 32'hFFFF_FFFC))
            $display("FAIL rnd%0d_port: got be=%b we=%b addr=%h want %b %b %h", n, dmem_be, dmem_we, dmem_addr,
                     model_be(ins), ins.mw, ins.alu & 32'hFFFF_FFFC); else n_pass++;
          if (ins.mw) begin
            n_checks++; if (dmem_wdata !== model_wdata(ins)) $display("FAIL rnd%0d_wdata: got %h want %h", n, dmem_wdata, model_wdata(ins)); else n_pass++;
          end
        end
        done = !mem || (ins.mw && g) || r;
        if (g && ins.mr) begin granted = 1'b1; rv_at = cyc + 1 + rdel; end
        tick();
        if (done) begin
          exp = exp_q.pop_front();
          n_checks++; if (memwb_o !== exp) $display("FAIL rnd%0d_memwb: got %h want %h", n, memwb_o, exp); else n_pass++;
        end else begin
          n_checks++; if (memwb_o !== '0) $display("FAIL rnd%0d_bubble c%0d: got %h want 0", n, cyc, memwb_o); else n_pass++;
        end
        cyc++;
      end
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alu();
    test_sb();
    test_lb(1'b1);
    test_lb(1'b0);
    test_lw_wait();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
